// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment table, control bit positions and BCD sizing shared by the 7-segment controller
package seven_seg_pkg;
  localparam int CTRL_HEX = 0;
  localparam int CTRL_BLZ = 1;
  localparam int CTRL_EN = 2;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction
endpackage

// File: rtl/seven_seg_scan_ctrl_bin2bcd.sv
// seq_bin2bcd: sequential shift-add-3 binary to BCD converter, one input bit per cycle, restartable
module seq_bin2bcd #(
  parameter int DATA_W = 32,
  parameter int NUM_BCD = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_W-1:0]      din,
  output logic                   busy,
  output logic                   done,
  output logic [4*NUM_BCD-1:0]   bcd
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [DATA_W-1:0] r_sh;
  logic [CW-1:0] r_cnt;
  logic [4*NUM_BCD-1:0] w_adj;
  always_comb begin
    w_adj = bcd;
    for (int i = 0; i < NUM_BCD; i++)
      w_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
      r_sh <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_sh <= din << 1;
      bcd <= {{(4*NUM_BCD-1){1'b0}}, din[DATA_W-1]};
      r_cnt <= CW'(DATA_W - 1);
      busy <= 1'b1;
      done <= DATA_W == 1;
    end else if (busy && r_cnt != '0) begin
      bcd <= {w_adj[4*NUM_BCD-2:0], r_sh[DATA_W-1]};
      r_sh <= r_sh << 1;
      r_cnt <= r_cnt - 1'b1;
      done <= r_cnt == CW'(1);
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: bus-writable multiplexed 7-segment display controller with hex/decimal conversion
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W = 32,
  parameter int REFRESH_DIV = 10000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_7seg,
  input  logic                  wsel,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  busy,
  output logic                  ovf,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g,
  output logic [NUM_DIGITS-1:0] AN
);
  localparam int NB = bcd_digits(DATA_W);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic POL = ACTIVE_LOW != 0;
  logic [DATA_W-1:0] r_value;
  logic r_hex, r_blz, r_en;
  logic [BW-1:0] r_buf;
  logic [PW-1:0] r_pre;
  logic [IW-1:0] r_idx;
  logic [6:0] r_cur, r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic w_val_wr, w_ctl_wr, w_lhex, w_launch, w_start, w_cnv_rst, w_done, w_tc, w_nblank;
  logic [DATA_W-1:0] w_lval;
  logic [4*NB-1:0] w_bcd;
  logic [BW+DATA_W-1:0] w_hex_ext;
  logic [BW+4*NB-1:0] w_bcd_ext;
  logic [IW-1:0] w_nidx;
  logic [3:0] w_ndig;
  assign w_val_wr = we_7seg & ~wsel;
  assign w_ctl_wr = we_7seg & wsel;
  assign w_lhex = w_ctl_wr ? wdata[CTRL_HEX] : r_hex;
  assign w_launch = w_val_wr | (w_ctl_wr & (wdata[CTRL_HEX] != r_hex));
  assign w_lval = w_val_wr ? wdata : r_value;
  assign w_start = w_launch & ~w_lhex;
  assign w_cnv_rst = rst | (w_launch & w_lhex);
  assign w_hex_ext = {{BW{1'b0}}, w_lval};
  assign w_bcd_ext = {{BW{1'b0}}, w_bcd};
  assign w_tc = r_pre == PW'(REFRESH_DIV - 1);
  assign w_nidx = r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
  assign w_ndig = 4'(r_buf >> (4 * w_nidx));
  assign w_nblank = r_blz && w_nidx != '0 && (r_buf >> (4 * w_nidx)) == '0;
  assign {a, b, c, d, e, f, g} = r_seg;
  assign AN = r_an;
  seq_bin2bcd #(.DATA_W(DATA_W), .NUM_BCD(NB)) u_bcd (
    .clk(clk),
    .rst(w_cnv_rst),
    .start(w_start),
    .din(w_lval),
    .busy(busy),
    .done(w_done),
    .bcd(w_bcd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
      r_hex <= 1'b0;
      r_blz <= 1'b0;
      r_en <= 1'b1;
      r_buf <= '0;
      ovf <= 1'b0;
      r_pre <= '0;
      r_idx <= '0;
      r_cur <= SEG_TAB[0];
      r_seg <= {7{POL}};
      r_an <= {NUM_DIGITS{POL}};
    end else begin
      if (w_val_wr) r_value <= wdata;
      if (w_ctl_wr) begin
        r_hex <= wdata[CTRL_HEX];
        r_blz <= wdata[CTRL_BLZ];
        r_en <= wdata[CTRL_EN];
      end
      if (w_launch & w_lhex) begin
        r_buf <= w_hex_ext[BW-1:0];
        ovf <= |w_hex_ext[BW +: DATA_W];
      end else if (w_done & ~w_launch) begin
        r_buf <= w_bcd_ext[BW-1:0];
        ovf <= |w_bcd_ext[BW +: 4*NB];
      end
      r_pre <= w_tc ? '0 : r_pre + 1'b1;
      if (w_tc) begin
        r_idx <= w_nidx;
        r_cur <= w_nblank ? SEG_BLANK : SEG_TAB[w_ndig];
      end
      r_an <= r_en ? (NUM_DIGITS'(1) << r_idx) ^ {NUM_DIGITS{POL}} : {NUM_DIGITS{POL}};
      r_seg <= r_en ? r_cur ^ {7{POL}} : {7{POL}};
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed self-checking bench for the 7-segment scan controller
module tb_seven_seg_scan_ctrl;
  logic clk, rst, we_7seg, wsel;
  logic [31:0] wdata;
  logic busy, ovf, a, b, c, d, e, f, g;
  logic [7:0] AN;
  int tests = 0;
  int fails = 0;
  int nb;
  logic ovf_held;
  logic [7:0] exp_an;
  seven_seg_scan_ctrl #(.NUM_DIGITS(8), .DATA_W(32), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .we_7seg(we_7seg), .wsel(wsel), .wdata(wdata),
    .busy(busy), .ovf(ovf), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .AN(AN)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic wr(input logic sel, input logic [31:0] data);
    @(negedge clk);
    we_7seg = 1'b1;
    wsel = sel;
    wdata = data;
    @(negedge clk);
    we_7seg = 1'b0;
  endtask
  task automatic count_busy(output int n);
    n = 0;
    ovf_held = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      ovf_held &= ovf;
      @(negedge clk);
    end
  endtask
  task automatic frame(input string tag, input logic [31:0] digs, input logic [7:0] blank);
    int n = 0;
    logic [7:0] ea;
    logic [6:0] es;
    repeat (2) @(negedge clk);
    while (AN === 8'hFE && n < 64) begin @(negedge clk); n++; end
    while (AN !== 8'hFE && n < 64) begin @(negedge clk); n++; end
    chk({tag, " sync"}, {24'd0, AN}, 32'h0000_00FE);
    for (int k = 0; k < 8; k++) begin
      ea = ~(8'd1 << k);
      es = blank[k] ? 7'b0000000 : hex7(digs[4*k +: 4]);
      chk({tag, " an"}, {24'd0, AN}, {24'd0, ea});
      chk({tag, " seg"}, {25'd0, ~{a, b, c, d, e, f, g}}, {25'd0, es});
      repeat (4) @(negedge clk);
    end
  endtask
  initial begin
    rst = 1'b1;
    we_7seg = 1'b0;
    wsel = 1'b0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset an", {24'd0, AN}, 32'h0000_00FF);
    chk("reset seg", {25'd0, a, b, c, d, e, f, g}, 32'h0000_007F);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      exp_an = ~(8'd1 << ((i / 4) % 8));
      chk("walk an", {24'd0, AN}, {24'd0, exp_an});
      chk("walk seg", {25'd0, a, b, c, d, e, f, g}, 32'h0000_0001);
    end
    wr(1'b1, 32'b101);
    wr(1'b0, 32'hDEAD_BEEF);
    chk("hex busy", {31'd0, busy}, 32'd0);
    chk("hex ovf", {31'd0, ovf}, 32'd0);
    frame("hex deadbeef", 32'hDEAD_BEEF, 8'h00);
    wr(1'b1, 32'b110);
    chk("relaunch busy", {31'd0, busy}, 32'd1);
    wr(1'b0, 32'd1234);
    count_busy(nb);
    chk("1234 busy len", nb, 32'd32);
    chk("1234 ovf", {31'd0, ovf}, 32'd0);
    frame("dec 1234", 32'h0000_1234, 8'hF0);
    wr(1'b0, 32'd4294967295);
    count_busy(nb);
    chk("max busy len", nb, 32'd32);
    chk("max ovf", {31'd0, ovf}, 32'd1);
    frame("dec max", 32'h9496_7295, 8'h00);
    wr(1'b0, 32'd1111);
    repeat (9) @(negedge clk);
    chk("1111 still busy", {31'd0, busy}, 32'd1);
    wr(1'b0, 32'd42);
    count_busy(nb);
    chk("restart busy len", nb, 32'd32);
    chk("old result held", {31'd0, ovf_held}, 32'd1);
    chk("42 ovf", {31'd0, ovf}, 32'd0);
    frame("dec 42", 32'h0000_0042, 8'hFC);
    wr(1'b1, 32'b010);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      chk("disabled an", {24'd0, AN}, 32'h0000_00FF);
      chk("disabled seg", {25'd0, a, b, c, d, e, f, g}, 32'h0000_007F);
      @(negedge clk);
    end
    wr(1'b1, 32'b110);
    repeat (2) @(negedge clk);
    chk("reenable onehot", {31'd0, $onehot(~AN)}, 32'd1);
    frame("reenable 42", 32'h0000_0042, 8'hFC);
    wr(1'b0, 32'd1234);
    repeat (3) @(negedge clk);
    chk("pre-rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst an", {24'd0, AN}, 32'h0000_00FF);
    chk("rst ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    frame("after rst", 32'h0000_0000, 8'h00);
    chk("after rst busy", {31'd0, busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
